reg_transfer_seq: RTL and testbench
===================================

Name: reg_transfer_seq

Overview:
Sequencer that performs register-to-register moves across a bank of bus-attached registers. On a request it enables one source register onto the shared read bus, captures the bus value, then strobes that value into one destination register. It is the consumer/driver on the other side of each register's tri-state output and load ports. It sits between the control unit (issues moves) and the register bank (rd_en to each out0_en, wr_load/wr_data to each load/data_in).

Parameters:
DATA_BITS, 8, width of register data and bus
NUM_REGS, 4, number of registers in the bank (2..16)
IDX_BITS, 2, width of register index ports; must satisfy 2**IDX_BITS >= NUM_REGS

Ports:
clk  input  1  system clock; sequencer state updates on posedge
reset_n  input  1  asynchronous active-low reset
req  input  1  start transfer; sampled only in IDLE
src_idx  input  IDX_BITS  source register index, sampled with req
dst_idx  input  IDX_BITS  destination register index, sampled with req
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  one-cycle pulse when a request is rejected
rd_en  output  NUM_REGS  one-hot (or zero) source output enable, drives register out0_en
bus_in  input  DATA_BITS  shared read bus (tri-state resolved)
wr_load  output  NUM_REGS  one-hot (or zero) destination load strobe
wr_data  output  DATA_BITS  data presented to destination register data_in
xfer_data  output  DATA_BITS  last value captured from bus_in

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, error=0, rd_en=0, wr_load=0, wr_data=0, xfer_data=0. Applies immediately, mid-transfer included; wr_load drops before the next negedge so no partial write reaches the bank.
- State updates on posedge only; registers load on negedge, so every strobe is stable for a full cycle across that negedge.
- States: IDLE, DRIVE, CAPTURE, WRITE, DONE.
- IDLE: busy=0, all strobes 0. On posedge with req=1: if src_idx>=NUM_REGS or dst_idx>=NUM_REGS -> error=1 for one cycle, stay IDLE; else latch src/dst, go DRIVE.
- DRIVE: rd_en[src]=1 (one cycle, bus settles). -> CAPTURE.
- CAPTURE: rd_en[src] still 1; at posedge leaving CAPTURE, xfer_data<=bus_in. -> WRITE.
- WRITE: rd_en=0; wr_load[dst]=1; wr_data=xfer_data, held the whole cycle. -> DONE.
- DONE: wr_load=0; done=1 for exactly one cycle. -> IDLE.
- Latency: req sampled at posedge N; done high during cycle N+4; next req accepted at posedge N+5. Throughput 1 transfer / 5 cycles.
- req while busy: ignored, not queued; src_idx/dst_idx changes while busy have no effect.
- src_idx==dst_idx: legal; value read and written back unchanged, done pulses normally.
- rd_en and wr_load are never simultaneously nonzero; at most one bit of each set in any cycle.
- wr_data holds the last captured value outside WRITE (changes only at CAPTURE exit or reset).
- bus_in is ignored outside CAPTURE.

Test Plan:
- Reset: reg bank R0..R3=0x11,0x22,0x33,0x44; reset_n=0 mid-DRIVE -> all outputs 0 immediately, state IDLE, bank unchanged.
- Basic move: req src=2 dst=0 -> rd_en=0100 for 2 cycles, xfer_data=0x33, wr_load=0001 for 1 cycle, done pulse at req+4, R0=0x33, R2=0x33.
- Self move: req src=1 dst=1 -> done pulses, R1 stays 0x22, no other register loaded.
- Busy rejection: req src=3 dst=0 then req src=0 dst=2 one cycle later -> only first executes (R0=0x44), R2 unchanged, single done pulse.
- Invalid index (NUM_REGS=3, IDX_BITS=2): req src=3 dst=0 -> error pulse one cycle, busy stays 0, rd_en/wr_load stay 0, no register changes.
- Back-to-back: req held high continuously src=0 dst=3 -> transfers start every 5 cycles, done pulses 5 cycles apart, R3=0x11, rd_en/wr_load never overlap.

Source files
------------

// File: rtl/reg_transfer_seq_if.sv
// rtl/reg_transfer_seq_if.sv - control/bank signal bundle for the register transfer sequencer.
interface reg_transfer_seq_if #(
   parameter int DATA_BITS = 8,
   parameter int NUM_REGS  = 4,
   parameter int IDX_BITS  = 2
);
   logic                 req;
   logic [IDX_BITS-1:0]  src_idx;
   logic [IDX_BITS-1:0]  dst_idx;
   logic                 busy;
   logic                 done;
   logic                 error;
   logic [NUM_REGS-1:0]  rd_en;
   logic [DATA_BITS-1:0] bus_in;
   logic [NUM_REGS-1:0]  wr_load;
   logic [DATA_BITS-1:0] wr_data;
   logic [DATA_BITS-1:0] xfer_data;

   modport master (
      input  req, src_idx, dst_idx, bus_in,
      output busy, done, error, rd_en, wr_load, wr_data, xfer_data
   );

   modport slave (
      output req, src_idx, dst_idx, bus_in,
      input  busy, done, error, rd_en, wr_load, wr_data, xfer_data
   );
endinterface

// File: rtl/reg_transfer_seq.sv
// rtl/reg_transfer_seq.sv - moves one bus register into another: drive, capture, write, done.
module reg_transfer_seq #(
   parameter int DATA_BITS = 8,
   parameter int NUM_REGS  = 4,
   parameter int IDX_BITS  = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   reg_transfer_seq_if.master     bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_CAPTURE,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [IDX_BITS:0] IDX_LIMIT = NUM_REGS[IDX_BITS:0];

   state_t               state_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 error_q;
   logic [NUM_REGS-1:0]  rd_en_q;
   logic [NUM_REGS-1:0]  wr_load_q;
   logic [DATA_BITS-1:0] data_q;
   logic [IDX_BITS-1:0]  dst_q;
   logic                 idx_bad;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_BITS-1:0] idx);
      return NUM_REGS'(1) << idx;
   endfunction

   assign idx_bad = ({1'b0, bus.src_idx} >= IDX_LIMIT) || ({1'b0, bus.dst_idx} >= IDX_LIMIT);

   // Strobes change only on posedge so the bank's negedge load sees them stable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         rd_en_q   <= '0;
         wr_load_q <= '0;
         data_q    <= '0;
         dst_q     <= '0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  if (idx_bad) begin
                     error_q <= 1'b1;
                  end else begin
                     dst_q   <= bus.dst_idx;
                     rd_en_q <= onehot(bus.src_idx);
                     busy_q  <= 1'b1;
                     state_q <= S_DRIVE;
                  end
               end
            end
            S_DRIVE: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               data_q    <= bus.bus_in;
               rd_en_q   <= '0;
               wr_load_q <= onehot(dst_q);
               state_q   <= S_WRITE;
            end
            S_WRITE: begin
               wr_load_q <= '0;
               done_q    <= 1'b1;
               state_q   <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q    <= 1'b0;
               rd_en_q   <= '0;
               wr_load_q <= '0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.wr_load   = wr_load_q;
   assign bus.wr_data   = data_q;
   assign bus.xfer_data = data_q;
endmodule

// File: tb/tb_reg_transfer_seq.sv
// tb/tb_reg_transfer_seq.sv - scoreboard bench for reg_transfer_seq with a 4-register and a 3-register bank.
module tb_reg_transfer_seq;
   logic clk = 1'b0;
   logic reset_n;
   logic bank_init;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   reg_transfer_seq_if #(.DATA_BITS(8), .NUM_REGS(4), .IDX_BITS(2)) if4 ();
   reg_transfer_seq_if #(.DATA_BITS(8), .NUM_REGS(3), .IDX_BITS(2)) if3 ();

   reg_transfer_seq #(.DATA_BITS(8), .NUM_REGS(4), .IDX_BITS(2)) dut4 (
      .clk(clk), .reset_n(reset_n), .bus(if4)
   );
   reg_transfer_seq #(.DATA_BITS(8), .NUM_REGS(3), .IDX_BITS(2)) dut3 (
      .clk(clk), .reset_n(reset_n), .bus(if3)
   );

   logic [7:0] bank [4];

   // Register bank: tri-state read bus resolved to the enabled source, loads on negedge.
   always_comb begin
      if4.bus_in = 8'h00;
      for (int i = 0; i < 4; i++)
         if (if4.rd_en[i]) if4.bus_in = bank[i];
   end
   assign if3.bus_in = 8'hA5;

   always @(negedge clk) begin
      if (bank_init) begin
         bank[0] <= 8'h11;
         bank[1] <= 8'h22;
         bank[2] <= 8'h33;
         bank[3] <= 8'h44;
      end else begin
         for (int i = 0; i < 4; i++)
            if (if4.wr_load[i]) bank[i] <= if4.wr_data;
      end
   end

   typedef struct {
      int         dst;
      logic [7:0] data;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   // Scoreboard: every load strobe must match the oldest expected write.
   always @(negedge clk) begin
      n_cmp++;
      if ((if4.rd_en != 4'b0 && if4.wr_load != 4'b0) || $countones(if4.rd_en) > 1
          || $countones(if4.wr_load) > 1) begin
         n_err++;
         $display("FAIL strobe_exclusive at %0t: rd_en=%b wr_load=%b", $time, if4.rd_en, if4.wr_load);
      end
      if (if4.wr_load != 4'b0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write at %0t: wr_load=%b wr_data=%h, none expected",
                     $time, if4.wr_load, if4.wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (if4.wr_load !== (4'b0001 << mon_e.dst) || if4.wr_data !== mon_e.data) begin
               n_err++;
               $display("FAIL write_data at %0t: wr_load=%b wr_data=%h, expected dst=%0d data=%h",
                        $time, if4.wr_load, if4.wr_data, mon_e.dst, mon_e.data);
            end
         end
      end
   end

   task automatic test_reset();
      reset_n   = 1'b1;
      bank_init = 1'b1;
      if4.req = 1'b0; if4.src_idx = '0; if4.dst_idx = '0;
      if3.req = 1'b0; if3.src_idx = '0; if3.dst_idx = '0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({if4.busy, if4.done, if4.error, if4.rd_en, if4.wr_load, if4.wr_data, if4.xfer_data} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: busy=%b done=%b error=%b rd_en=%b wr_load=%b wr_data=%h xfer=%h, all zero required",
                  if4.busy, if4.done, if4.error, if4.rd_en, if4.wr_load, if4.wr_data, if4.xfer_data);
      end
      bank_init = 1'b0;
      reset_n   = 1'b1;
      @(negedge clk);
      if4.req = 1'b1; if4.src_idx = 2'd2; if4.dst_idx = 2'd0;
      @(negedge clk);
      if4.req = 1'b0;
      n_cmp++;
      if (if4.rd_en !== 4'b0100 || if4.busy !== 1'b1) begin
         n_err++;
         $display("FAIL reset_drive_phase: rd_en=%b busy=%b, expected 0100/1", if4.rd_en, if4.busy);
      end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({if4.busy, if4.done, if4.error, if4.rd_en, if4.wr_load, if4.wr_data, if4.xfer_data} !== '0) begin
         n_err++;
         $display("FAIL reset_async: busy=%b rd_en=%b wr_load=%b, all zero required immediately",
                  if4.busy, if4.rd_en, if4.wr_load);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (if4.busy !== 1'b0 || if4.done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_stays_idle: busy=%b done=%b, expected 0/0", if4.busy, if4.done);
      end
      n_cmp++;
      if (bank[0] !== 8'h11 || bank[1] !== 8'h22 || bank[2] !== 8'h33 || bank[3] !== 8'h44) begin
         n_err++;
         $display("FAIL reset_bank: %h %h %h %h, expected 11 22 33 44", bank[0], bank[1], bank[2], bank[3]);
      end
   endtask

   task automatic test_basic_move();
      if4.req = 1'b1; if4.src_idx = 2'd2; if4.dst_idx = 2'd0;
      exp_q.push_back('{dst: 0, data: 8'h33});
      @(negedge clk);
      if4.req = 1'b0;
      n_cmp++;
      if (if4.rd_en !== 4'b0100 || if4.wr_load !== 4'b0 || if4.busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_drive: rd_en=%b wr_load=%b busy=%b, expected 0100/0000/1", if4.rd_en, if4.wr_load, if4.busy);
      end
      @(negedge clk);
      n_cmp++;
      if (if4.rd_en !== 4'b0100 || if4.wr_load !== 4'b0) begin
         n_err++;
         $display("FAIL basic_capture: rd_en=%b wr_load=%b, expected 0100/0000", if4.rd_en, if4.wr_load);
      end
      @(negedge clk);
      n_cmp++;
      if (if4.rd_en !== 4'b0 || if4.wr_load !== 4'b0001 || if4.xfer_data !== 8'h33 || if4.wr_data !== 8'h33) begin
         n_err++;
         $display("FAIL basic_write: rd_en=%b wr_load=%b xfer=%h wr_data=%h, expected 0000/0001/33/33",
                  if4.rd_en, if4.wr_load, if4.xfer_data, if4.wr_data);
      end
      @(negedge clk);
      n_cmp++;
      if (if4.done !== 1'b1 || if4.wr_load !== 4'b0 || if4.busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_done: done=%b wr_load=%b busy=%b, expected 1/0000/1", if4.done, if4.wr_load, if4.busy);
      end
      @(negedge clk);
      n_cmp++;
      if (if4.done !== 1'b0 || if4.busy !== 1'b0 || if4.wr_data !== 8'h33) begin
         n_err++;
         $display("FAIL basic_idle: done=%b busy=%b wr_data=%h, expected 0/0/33", if4.done, if4.busy, if4.wr_data);
      end
      n_cmp++;
      if (bank[0] !== 8'h33 || bank[2] !== 8'h33) begin
         n_err++;
         $display("FAIL basic_bank: R0=%h R2=%h, expected 33/33", bank[0], bank[2]);
      end
   endtask

   task automatic test_self_move();
      bit seen = 1'b0;
      if4.req = 1'b1; if4.src_idx = 2'd1; if4.dst_idx = 2'd1;
      exp_q.push_back('{dst: 1, data: 8'h22});
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if4.req = 1'b0;
         if (if4.done === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL self_done: done=0 after 8 cycles, pulse required");
      end
      @(negedge clk);
      n_cmp++;
      if (bank[0] !== 8'h33 || bank[1] !== 8'h22 || bank[2] !== 8'h33 || bank[3] !== 8'h44) begin
         n_err++;
         $display("FAIL self_bank: %h %h %h %h, expected 33 22 33 44", bank[0], bank[1], bank[2], bank[3]);
      end
   endtask

   task automatic test_busy_reject();
      int dones = 0;
      if4.req = 1'b1; if4.src_idx = 2'd3; if4.dst_idx = 2'd0;
      exp_q.push_back('{dst: 0, data: 8'h44});
      @(negedge clk);
      if4.src_idx = 2'd0; if4.dst_idx = 2'd2;
      @(negedge clk);
      if4.req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (if4.done === 1'b1) dones++;
         @(negedge clk);
      end
      n_cmp++;
      if (dones != 1) begin
         n_err++;
         $display("FAIL busy_done_count: %0d pulses, expected 1", dones);
      end
      n_cmp++;
      if (bank[0] !== 8'h44 || bank[2] !== 8'h33) begin
         n_err++;
         $display("FAIL busy_bank: R0=%h R2=%h, expected 44/33", bank[0], bank[2]);
      end
   endtask

   task automatic test_invalid_index();
      logic [1:0] srcs [2] = '{2'd3, 2'd0};
      logic [1:0] dsts [2] = '{2'd0, 2'd3};
      for (int t = 0; t < 2; t++) begin
         if3.req = 1'b1; if3.src_idx = srcs[t]; if3.dst_idx = dsts[t];
         @(negedge clk);
         if3.req = 1'b0;
         n_cmp++;
         if (if3.error !== 1'b1 || if3.busy !== 1'b0 || if3.rd_en !== 3'b0) begin
            n_err++;
            $display("FAIL invalid_error[%0d]: error=%b busy=%b rd_en=%b, expected 1/0/000",
                     t, if3.error, if3.busy, if3.rd_en);
         end
         @(negedge clk);
         n_cmp++;
         if (if3.error !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_pulse_width[%0d]: error=%b, expected 0", t, if3.error);
         end
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (if3.busy !== 1'b0 || if3.rd_en !== 3'b0 || if3.wr_load !== 3'b0 || if3.done !== 1'b0) begin
               n_err++;
               $display("FAIL invalid_quiet[%0d]: busy=%b rd_en=%b wr_load=%b done=%b, expected all 0",
                        t, if3.busy, if3.rd_en, if3.wr_load, if3.done);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_back_to_back();
      int done_at[$];
      @(posedge clk);
      bank_init = 1'b1;
      @(posedge clk);
      bank_init = 1'b0;
      @(negedge clk);
      if4.req = 1'b1; if4.src_idx = 2'd0; if4.dst_idx = 2'd3;
      repeat (3) exp_q.push_back('{dst: 3, data: 8'h11});
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (if4.done === 1'b1) done_at.push_back(i);
         if (i == 11) if4.req = 1'b0;
      end
      n_cmp++;
      if (done_at.size() != 3) begin
         n_err++;
         $display("FAIL b2b_done_count: %0d pulses, expected 3", done_at.size());
      end else begin
         n_cmp++;
         if (done_at[0] != 4 || done_at[1] - done_at[0] != 5 || done_at[2] - done_at[1] != 5) begin
            n_err++;
            $display("FAIL b2b_spacing: done at %0d,%0d,%0d, expected 4,9,14",
                     done_at[0], done_at[1], done_at[2]);
         end
      end
      n_cmp++;
      if (bank[3] !== 8'h11 || bank[0] !== 8'h11) begin
         n_err++;
         $display("FAIL b2b_bank: R3=%h R0=%h, expected 11/11", bank[3], bank[0]);
      end
   endtask

   initial begin
      test_reset();
      test_basic_move();
      test_self_move();
      test_busy_reject();
      test_invalid_index();
      test_back_to_back();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d expected writes never seen, 0 required", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
